// File: rtl/wb_cmd_master.sv
// Wishbone classic (B3) initiator: buffers local read/write commands in a small FIFO,
// issues them one at a time with an ack timeout, and returns in-order responses.
module wb_cmd_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [DATA_W/8-1:0] cmd_sel,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // ---------------- command FIFO ----------------
    cmd_t           mem [CMD_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           empty, full, push, pop;
    cmd_t           head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // ---------------- bus / response FSM ----------------
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              cyc, cyc_nxt;
    cmd_t              bus, bus_nxt;
    logic              rv, rv_nxt;
    logic [DATA_W-1:0] rdata, rdata_nxt;
    logic              err, err_nxt;

    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cyc_nxt   = cyc;
        bus_nxt   = bus;
        rv_nxt    = rv;
        rdata_nxt = rdata;
        err_nxt   = err;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    bus_nxt   = head;
                    cyc_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    cyc_nxt   = 1'b0;
                    rdata_nxt = bus.we ? '0 : wbm_dat_i;
                    err_nxt   = 1'b0;
                    rv_nxt    = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    cyc_nxt   = 1'b0;
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    rv_nxt    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            cyc   <= 1'b0;
            bus   <= '0;
            rv    <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cyc   <= cyc_nxt;
            bus   <= bus_nxt;
            rv    <= rv_nxt;
            rdata <= rdata_nxt;
            err   <= err_nxt;
        end
    end

    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = bus.we;
    assign wbm_sel_o = bus.sel;
    assign wbm_adr_o = bus.adr;
    assign wbm_dat_o = bus.dat;
    assign rsp_valid = rv;
    assign rsp_rdata = rdata;
    assign rsp_err   = err;
    assign busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: scripted commands, a configurable slave model,
// and scoreboards for the bus cycles issued and the responses returned.
module tb_wb_cmd_master;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        wb_rst_ni;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    wb_cmd_master #(.CMD_DEPTH(4), .TIMEOUT(TIMEOUT), .ADDR_W(32), .DATA_W(32)) dut (
        .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   len_q[$];
    int   rise_q[$];

    int pass_cnt = 0;
    int total    = 0;
    int cyc_num  = 0;
    int bus_starts = 0;
    int rsp_cnt  = 0;
    logic hs_busy = 1'b0;

    // Slave behaviour: ack on the ack_at-th cycle of cyc (0 = never ack).
    int          ack_at = 1;
    logic [31:0] slave_rdata = 32'h0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic rsp_t model(input logic we);
        rsp_t r;
        if (ack_at == 0 || ack_at > TIMEOUT) begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
        end else begin
            r.rdata = we ? 32'h0 : slave_rdata;
            r.err   = 1'b0;
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_num++;
    end

    // Slave model: decides ack for the coming edge from the current cyc state.
    initial begin
        int cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hx;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o) begin
                cnt++;
                wbm_ack_i = (ack_at != 0) && (cnt == ack_at);
            end else begin
                cnt = 0;
                wbm_ack_i = 1'b0;
            end
            wbm_dat_i = wbm_ack_i ? slave_rdata : 32'hx;
        end
    end

    // Bus monitor: checks each issued cycle against the command scoreboard.
    initial begin
        logic prev = 1'b0;
        logic stable = 1'b1;
        int   len = 0;
        bus_t cur, now, e;
        forever begin
            @(negedge clk);
            now = '{we: wbm_we_o, sel: wbm_sel_o, adr: wbm_adr_o, dat: wbm_dat_o};
            if (wbm_cyc_o && !prev) begin
                bus_starts++;
                rise_q.push_back(cyc_num);
                cur    = now;
                len    = 1;
                stable = wbm_stb_o;
                check("bus_expected", bus_q.size() != 0, 1'b1);
                if (bus_q.size() != 0) begin
                    e = bus_q.pop_front();
                    check("bus_cmd", cur, e);
                end
            end else if (wbm_cyc_o) begin
                len++;
                if (now !== cur || wbm_stb_o !== 1'b1) stable = 1'b0;
            end else if (prev) begin
                len_q.push_back(len);
                check("bus_stable", stable, 1'b1);
            end
            prev = wbm_cyc_o;
        end
    end

    // Response monitor: a handshake seen here completes at the next edge.
    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            hs_busy = busy;
            check("rsp_expected", rsp_q.size() != 0, 1'b1);
            if (rsp_q.size() != 0) begin
                e = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, output int waited);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        check("cmd_accepted", ok, 1'b1);
        @(posedge clk);
        if (ok) begin
            bus_q.push_back('{we: we, sel: sel, adr: adr, dat: dat});
            rsp_q.push_back(model(we));
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!busy && !wbm_cyc_o && !rsp_valid && rsp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_reached", done, 1'b1);
    endtask

    task automatic check_len(input string tag, input int exp);
        check({tag, "_recorded"}, len_q.size() != 0, 1'b1);
        if (len_q.size() != 0) check(tag, len_q.pop_front(), exp);
    endtask

    initial begin
        int w, wsum, base, snap_bus, snap_rsp;
        bit done;
        wb_rst_ni = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_stb", wbm_stb_o, 1'b0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        wb_rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        // 1: write, ack on the 3rd cyc cycle
        ack_at = 3;
        send(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, w);
        wait_idle();
        check_len("wr_len", 3);

        // 2: zero-wait read, latency checks
        ack_at = 1;
        slave_rdata = 32'h1234_5678;
        send(1'b0, 4'hF, 32'h3000_0000, 32'h0, w);
        check("rd_cyc_not_yet", wbm_cyc_o, 1'b0);
        @(posedge clk);
        #1;
        check("rd_cyc_k1", wbm_cyc_o, 1'b1);
        @(posedge clk);
        #1;
        check("rd_cyc_dropped", wbm_cyc_o, 1'b0);
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_data_now", rsp_rdata, 32'h1234_5678);
        wait_idle();
        check_len("rd_len", 1);

        // 3: timeout, then ack on the last allowed cycle
        ack_at = 0;
        slave_rdata = 32'hCAFE_0001;
        send(1'b0, 4'h3, 32'h3000_0008, 32'h0, w);
        wait_idle();
        check_len("to_len", TIMEOUT);
        ack_at = TIMEOUT;
        send(1'b0, 4'hC, 32'h3000_000C, 32'h0, w);
        wait_idle();
        check_len("late_ack_len", TIMEOUT);

        // 4: fill the FIFO with responses stalled
        ack_at = 1;
        slave_rdata = 32'h0BAD_F00D;
        rsp_ready = 1'b0;
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            send(i[0], 4'h1 << (i % 4), 32'h3000_0100 + 32'(i * 4), 32'h1111_0000 + 32'(i), w);
            wsum += w;
        end
        check("fill_no_stall", wsum, 0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h3000_0200; cmd_dat = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ready_low", cmd_ready, 1'b0);
        end
        check("full_rsp_held", rsp_valid, 1'b1);
        check("full_busy", busy, 1'b1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        send(1'b1, 4'hF, 32'h3000_0200, 32'h6666_6666, w);
        check("sixth_waited", w > 0, 1'b1);
        wait_idle();
        for (int i = 0; i < 6; i++) check_len("fill_len", 1);

        // 5: reset in the 2nd BUS cycle with two commands queued
        ack_at = 0;
        send(1'b0, 4'hF, 32'h3000_0300, 32'h0, w);
        send(1'b1, 4'hF, 32'h3000_0304, 32'h7777_0000, w);
        send(1'b1, 4'hF, 32'h3000_0308, 32'h8888_0000, w);
        check("pre_rst_cyc", wbm_cyc_o, 1'b1);
        #2 wb_rst_ni = 1'b0;
        #1;
        check("midrst_cyc", wbm_cyc_o, 1'b0);
        check("midrst_stb", wbm_stb_o, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        bus_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        wb_rst_ni = 1'b1;
        len_q.delete();
        snap_bus = bus_starts;
        snap_rsp = rsp_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("postrst_no_bus", bus_starts, snap_bus);
        check("postrst_no_rsp", rsp_cnt, snap_rsp);
        check("postrst_busy", busy, 1'b0);

        // 6: back-to-back zero-wait writes
        ack_at = 1;
        rise_q.delete();
        base = rsp_cnt;
        for (int i = 0; i < 4; i++)
            send(1'b1, 4'hF, 32'h3000_0400 + 32'(i * 4), 32'hA000_0000 + 32'(i), w);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rsp_cnt == base + 4) begin
                done = 1'b1;
                break;
            end
        end
        check("b2b_done", done, 1'b1);
        check("b2b_busy_at_hs", hs_busy, 1'b1);
        check("b2b_busy_after", busy, 1'b0);
        check("b2b_rises", rise_q.size(), 4);
        for (int i = 1; i < rise_q.size(); i++)
            check("b2b_spacing", rise_q[i] - rise_q[i-1], 3);
        wait_idle();
        while (len_q.size() != 0) check_len("b2b_len", 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total);
        $fatal(1, "watchdog");
    end

endmodule
